cmvn_inverse: RTL and testbench

Streaming inverse-CMVN (de-normalisation) engine for the KWS feature path: converts normalised feature samples back to the raw log-mel domain as y = ((x · std) >> FRAC_BITS) + mean, one bin at a time, for a frame block of NUM_FRAMES × NUM_BINS samples. It is the reverse counterpart of the forward `cmvn` normaliser. It is used on the readback/debug path and by the bench to reconstruct features for cross-checking. Per-bin mean and std coefficients live in a writable register table; samples move through valid/ready handshakes on both sides with a 2-stage pipeline.

---
 rtl/cmvn_inverse.sv | 171 +++++++++++++++++
 tb/tb_cmvn_inverse.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmvn_inverse.sv
// Streaming inverse-CMVN: y = ((x * std[bin]) >> FRAC_BITS) + mean[bin], 2-stage pipeline.
// Optional output clamping and sticky sat_flag enabled by defining CMVN_INV_SAT_EN.
module cmvn_inverse #(
  parameter int unsigned NUM_BINS   = 20,
  parameter int unsigned NUM_FRAMES = 50,
  parameter int unsigned FRAC_BITS  = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               coef_we,
  input  logic               coef_sel,
  input  logic [4:0]         coef_addr,
  input  logic signed [31:0] coef_wdata,
  input  logic               in_valid,
  input  logic signed [31:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic signed [31:0] out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               sat_flag
);

  localparam int unsigned BlockLen = NUM_BINS * NUM_FRAMES;
  localparam int unsigned CntW     = $clog2(BlockLen);
  localparam logic signed [31:0] StdOne  = 32'sd1 <<< FRAC_BITS;
  localparam logic signed [63:0] RndHalf = 64'sd1 <<< (FRAC_BITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic signed [31:0] mean_q [NUM_BINS];
  logic signed [31:0] std_q  [NUM_BINS];

  logic [4:0]         bin_q, bin_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic               s1_valid_q;
  logic signed [63:0] s1_prod_q;
  logic [4:0]         s1_bin_q;

  logic               out_valid_q;
  logic signed [31:0] out_data_q;
  logic               sat_q;

  logic               adv;
  logic               accept;
  logic               last;
  logic               clear_blk;
  logic               coef_wr;
  logic signed [63:0] prod;
  logic signed [63:0] rnd;
  logic signed [40:0] sum;
  logic [31:0]        narrow;
  logic               clamp;

  // The whole pipeline stalls together while the output register is held.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && (state_q == StRun);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == CntW'(BlockLen - 1));
  assign coef_wr  = coef_we && (state_q == StIdle) && (32'(coef_addr) < NUM_BINS);

  assign prod = 64'(in_data) * 64'(std_q[bin_q]);
  assign rnd  = s1_prod_q + RndHalf;
  assign sum  = 41'(rnd >>> FRAC_BITS) + 41'(mean_q[s1_bin_q]);

`ifdef CMVN_INV_SAT_EN
  always_comb begin
    clamp  = (sum[40:31] != {10{sum[31]}});
    narrow = sum[31:0];
    if (clamp) begin
      narrow = sum[40] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[40:32];
  assign clamp         = 1'b0;
  assign narrow        = sum[31:0];
`endif

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    clear_blk = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          clear_blk = 1'b1;
        end
      end
      StRun: begin
        if (accept && last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!s1_valid_q && !out_valid_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear_blk) begin
      bin_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      bin_d = (bin_q == 5'(NUM_BINS - 1)) ? 5'd0 : bin_q + 5'd1;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_bin_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_BINS; i++) begin
        mean_q[i] <= '0;
        std_q[i]  <= StdOne;
      end
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      if (coef_wr) begin
        if (coef_sel) begin
          std_q[coef_addr] <= coef_wdata;
        end else begin
          mean_q[coef_addr] <= coef_wdata;
        end
      end
      if (adv) begin
        s1_valid_q  <= accept;
        out_valid_q <= s1_valid_q;
        if (accept) begin
          s1_prod_q <= prod;
          s1_bin_q  <= bin_q;
        end
        if (s1_valid_q) begin
          out_data_q <= narrow;
        end
      end
      if (clear_blk) begin
        sat_q <= 1'b0;
      end else if (adv && s1_valid_q && clamp) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_cmvn_inverse.sv
// Directed self-checking bench for cmvn_inverse; honours CMVN_INV_SAT_EN like the RTL.
`timescale 1ns/1ps
module tb_cmvn_inverse;
  localparam int N = 1000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               coef_we = 1'b0;
  logic               coef_sel = 1'b0;
  logic [4:0]         coef_addr = '0;
  logic signed [31:0] coef_wdata = '0;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_data = '0;
  logic               in_ready;
  logic               out_valid;
  logic signed [31:0] out_data;
  logic               out_ready = 1'b1;
  logic               busy;
  logic               done;
  logic               sat_flag;

  int errors = 0;
  int checks = 0;

  logic [31:0] in_vec  [N];
  logic [31:0] exp_vec [N];
  logic [31:0] got     [N];
  int n_got;
  int done_cnt;

  logic        st_rdy [5];
  logic        st_vld [5];
  logic [31:0] st_dat [5];
  int          st_idx [5];

  cmvn_inverse dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .coef_we    (coef_we),
    .coef_sel   (coef_sel),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  // Handshakes complete on the following rising edge; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (n_got < N) got[n_got] = out_data;
      n_got++;
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic clear_run();
    n_got = 0;
    done_cnt = 0;
    for (int i = 0; i < N; i++) got[i] = 'x;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_coef(input logic sel, input logic [4:0] addr, input logic [31:0] data,
                            input logic with_start);
    coef_we = 1'b1; coef_sel = sel; coef_addr = addr; coef_wdata = data; start = with_start;
    @(posedge clk); #1;
    coef_we = 1'b0; start = 1'b0;
  endtask

  task automatic start_block();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int stall_at, input int stall_len);
    int idx = 0;
    int cyc = 0;
    int k = 0;
    while (idx < n && cyc < 20000) begin
      in_valid = 1'b1;
      in_data = in_vec[idx];
      out_ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      if (!out_ready && k < 5) begin
        st_rdy[k] = in_ready; st_vld[k] = out_valid; st_dat[k] = out_data; st_idx[k] = n_got;
        k++;
      end
      if (in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic wait_done();
    int c = 0;
    while (done_cnt == 0 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    if (out_data !== 32'd0) begin errors++; $display("FAIL reset out_data got %h want 0", out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset sat_flag got %b want 0", sat_flag); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_identity();
    do_reset();
    for (int i = 0; i < N; i++) begin in_vec[i] = 32'h0500_0000; exp_vec[i] = 32'h0500_0000; end
    clear_run();
    start_block();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL identity busy_rise got %b want 1", busy); end
    feed(N, 0, 0);
    wait_done();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got[i] !== exp_vec[i]) begin
        errors++; $display("FAIL identity sample %0d got %h want %h", i, got[i], exp_vec[i]);
      end
    end
    checks += 3;
    if (n_got !== N) begin errors++; $display("FAIL identity count got %0d want %0d", n_got, N); end
    if (done_cnt !== 1) begin errors++; $display("FAIL identity done_pulses got %0d want 1", done_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL identity busy_fall got %b want 0", busy); end
  endtask

  task automatic test_scale_offset();
    do_reset();
    for (int i = 0; i < N; i++) begin
      in_vec[i] = 32'd0;
      exp_vec[i] = (i % 20 == 3) ? 32'd100 : 32'd0;
    end
    in_vec[3]  = -32'sd7; exp_vec[3]  = 32'd86;   // -14 + 100
    in_vec[23] = -32'sd8; exp_vec[23] = 32'd84;   // -16 + 100
    in_vec[4]  = 32'sd1;  exp_vec[4]  = 32'd1;    // 0.5 rounds up
    in_vec[24] = -32'sd1; exp_vec[24] = 32'd0;    // -0.5 rounds up to 0
    in_vec[44] = 32'sd3;  exp_vec[44] = 32'd2;    // 1.5 rounds up
    clear_run();
    write_coef(1'b1, 5'd3, 32'h0200_0000, 1'b0);
    write_coef(1'b1, 5'd4, 32'h0080_0000, 1'b0);
    write_coef(1'b0, 5'd3, 32'd100, 1'b1);        // lands together with start
    feed(N, 0, 0);
    wait_done();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got[i] !== exp_vec[i]) begin
        errors++; $display("FAIL scale_offset sample %0d got %h want %h", i, got[i], exp_vec[i]);
      end
    end
    checks++;
    if (n_got !== N) begin errors++; $display("FAIL scale_offset count got %0d want %0d", n_got, N); end
  endtask

  task automatic test_bin_wrap();
    do_reset();
    for (int k = 0; k < 20; k++) write_coef(1'b0, 5'(k), 32'(k * 1000), 1'b0);
    write_coef(1'b0, 5'd20, 32'd7777, 1'b0);       // out of range, dropped
    for (int i = 0; i < N; i++) begin in_vec[i] = 32'd0; exp_vec[i] = 32'((i % 20) * 1000); end
    clear_run();
    start_block();
    fork
      feed(N, 0, 0);
      begin
        repeat (10) @(posedge clk);
        #1 coef_we = 1'b1; coef_sel = 1'b0; coef_addr = 5'd0; coef_wdata = 32'd12345;
        @(posedge clk);
        #1 coef_we = 1'b0;
      end
    join
    wait_done();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got[i] !== exp_vec[i]) begin
        errors++; $display("FAIL bin_wrap sample %0d got %h want %h", i, got[i], exp_vec[i]);
      end
    end
    checks += 2;
    if (n_got !== N) begin errors++; $display("FAIL bin_wrap count got %0d want %0d", n_got, N); end
    if (done_cnt !== 1) begin errors++; $display("FAIL bin_wrap done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < N; i++) begin in_vec[i] = 32'(i); exp_vec[i] = 32'(i); end
    clear_run();
    start_block();
    feed(N, 100, 5);
    wait_done();
    for (int k = 0; k < 5; k++) begin
      checks += 3;
      if (st_rdy[k] !== 1'b0) begin
        errors++; $display("FAIL backpressure in_ready stall %0d got %b want 0", k, st_rdy[k]);
      end
      if (st_vld[k] !== 1'b1) begin
        errors++; $display("FAIL backpressure out_valid stall %0d got %b want 1", k, st_vld[k]);
      end
      if (st_dat[k] !== exp_vec[st_idx[k]]) begin
        errors++;
        $display("FAIL backpressure hold stall %0d got %h want %h", k, st_dat[k], exp_vec[st_idx[k]]);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got[i] !== exp_vec[i]) begin
        errors++; $display("FAIL backpressure sample %0d got %h want %h", i, got[i], exp_vec[i]);
      end
    end
    checks++;
    if (n_got !== N) begin errors++; $display("FAIL backpressure count got %0d want %0d", n_got, N); end
  endtask

  task automatic test_saturation();
    logic exp_sat;
    do_reset();
    write_coef(1'b1, 5'd0, 32'h7FFF_FFFF, 1'b0);
    write_coef(1'b0, 5'd0, 32'h7FFF_FFFF, 1'b0);
    write_coef(1'b1, 5'd1, 32'h7FFF_FFFF, 1'b0);
    write_coef(1'b0, 5'd1, 32'h8000_0000, 1'b0);
    for (int i = 0; i < N; i++) begin
      in_vec[i] = 32'd0;
      exp_vec[i] = (i % 20 == 0) ? 32'h7FFF_FFFF : ((i % 20 == 1) ? 32'h8000_0000 : 32'd0);
    end
    in_vec[0] = 32'h7FFF_FFFF;
    in_vec[1] = 32'h8000_0000;
`ifdef CMVN_INV_SAT_EN
    exp_vec[0] = 32'h7FFF_FFFF;
    exp_vec[1] = 32'h8000_0000;
    exp_sat = 1'b1;
`else
    exp_vec[0] = 32'h7FFF_FEFF;   // 2^38 - 256 + 2^31 - 1, low word
    exp_vec[1] = 32'h8000_0080;   // -2^38 + 128 - 2^31, low word
    exp_sat = 1'b0;
`endif
    clear_run();
    start_block();
    feed(N, 0, 0);
    wait_done();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got[i] !== exp_vec[i]) begin
        errors++; $display("FAIL saturation sample %0d got %h want %h", i, got[i], exp_vec[i]);
      end
    end
    checks++;
    if (sat_flag !== exp_sat) begin
      errors++; $display("FAIL saturation sat_flag got %b want %b", sat_flag, exp_sat);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    write_coef(1'b0, 5'd2, 32'd7, 1'b0);
    for (int i = 0; i < N; i++) in_vec[i] = 32'h0100_0000;
    clear_run();
    start_block();
    feed(300, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset in_ready got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid got %b want 0", out_valid); end
    if (out_data !== 32'd0) begin errors++; $display("FAIL midreset out_data got %h want 0", out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL midreset done got %b want 0", done); end
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL midreset sat_flag got %b want 0", sat_flag); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin in_vec[i] = 32'(i); exp_vec[i] = 32'(i); end
    clear_run();
    start_block();
    feed(N, 0, 0);
    wait_done();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got[i] !== exp_vec[i]) begin
        errors++; $display("FAIL midreset_rerun sample %0d got %h want %h", i, got[i], exp_vec[i]);
      end
    end
    checks += 2;
    if (n_got !== N) begin errors++; $display("FAIL midreset_rerun count got %0d want %0d", n_got, N); end
    if (done_cnt !== 1) begin errors++; $display("FAIL midreset_rerun done_pulses got %0d want 1", done_cnt); end
  endtask

  initial begin
    clear_run();
    #1;
    test_reset();
    test_identity();
    test_scale_offset();
    test_bin_wrap();
    test_backpressure();
    test_saturation();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
